// File: rtl/vector_lsu_sequencer.sv
// Vector load/store sequencer: walks the elements of one vector register (LMUL=1),
// issuing one memory word access per active element and merging load results into vd.
module vector_lsu_sequencer #(
    parameter int unsigned VLEN   = 128,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        eew,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       stride,
    input  logic [31:0]       vl,
    input  logic [31:0]       vstart,
    input  logic              vm,
    input  logic [VLEN-1:0]   masks,
    input  logic [VLEN-1:0]   vs_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       err_vstart,
    output logic [VLEN-1:0]   vd_result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned IdxW = $clog2(VLEN);

    typedef enum logic [1:0] {StIdle, StAccess, StFinish} state_e;

    state_e            state_q, state_d;
    logic              store_q;
    logic [1:0]        eew_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       stride_q;
    logic [31:0]       eff_vl_q;
    logic [31:0]       idx_q, idx_d;
    logic              vm_q;
    logic [VLEN-1:0]   masks_q;
    logic [VLEN-1:0]   vd_q, vd_d;
    logic              error_q, error_d;
    logic [31:0]       err_vstart_q, err_vstart_d;
    logic              latch_en;

    logic [31:0]        max_el, eff_vl;
    logic signed [31:0] prod;
    logic [ADDR_W-1:0]  elem_addr;
    logic [1:0]         off;
    logic [IdxW-1:0]    bit_pos;
    logic [31:0]        elem_mask;
    logic [3:0]         strb_base;
    logic [31:0]        store_elem, load_elem;
    logic [VLEN-1:0]    vd_load;
    logic               misaligned, active, last;

    // Per-element address, lane alignment and data steering for the element at idx_q
    always_comb begin
        max_el     = 32'(VLEN >> (3 + eew));
        eff_vl     = (vl < max_el) ? vl : max_el;
        prod       = $signed(idx_q) * $signed(stride_q);
        elem_addr  = base_q + ADDR_W'(prod);
        off        = elem_addr[1:0];
        bit_pos    = idx_q[IdxW-1:0] << (3 + eew_q);
        case (eew_q)
            2'd0:    begin elem_mask = 32'h0000_00FF; strb_base = 4'b0001; end
            2'd1:    begin elem_mask = 32'h0000_FFFF; strb_base = 4'b0011; end
            default: begin elem_mask = 32'hFFFF_FFFF; strb_base = 4'b1111; end
        endcase
        case (eew_q)
            2'd1:    misaligned = elem_addr[0];
            2'd2:    misaligned = |elem_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        store_elem = 32'(vd_q >> bit_pos) & elem_mask;
        load_elem  = (mem_rdata >> {off, 3'b000}) & elem_mask;
        vd_load    = (vd_q & ~(VLEN'(elem_mask) << bit_pos)) | (VLEN'(load_elem) << bit_pos);
        active     = vm_q | masks_q[idx_q[IdxW-1:0]];
        last       = (idx_q + 32'd1) >= eff_vl_q;
    end

    // Next-state, element bookkeeping and memory interface drive
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        vd_d         = vd_q;
        error_d      = error_q;
        err_vstart_d = err_vstart_q;
        latch_en     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch_en     = 1'b1;
                    vd_d         = vs_data;
                    idx_d        = vstart;
                    error_d      = 1'b0;
                    err_vstart_d = '0;
                    if (eew == 2'd3) begin
                        error_d      = 1'b1;
                        err_vstart_d = vstart;
                        state_d      = StFinish;
                    end else if (vstart >= eff_vl) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (!active) begin
                    idx_d = idx_q + 32'd1;
                    if (last) state_d = StFinish;
                end else if (misaligned) begin
                    // Fault before any access: earlier elements stay committed
                    error_d      = 1'b1;
                    err_vstart_d = idx_q;
                    state_d      = StFinish;
                end else begin
                    mem_req  = 1'b1;
                    mem_we   = store_q;
                    mem_addr = {elem_addr[ADDR_W-1:2], 2'b00};
                    if (store_q) begin
                        mem_wdata = store_elem << {off, 3'b000};
                        mem_wstrb = strb_base << off;
                    end
                    if (mem_ready) begin
                        if (!store_q) vd_d = vd_load;
                        idx_d = idx_q + 32'd1;
                        if (last) state_d = StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State and operand registers with synchronous reset
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q      <= StIdle;
            store_q      <= 1'b0;
            eew_q        <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            eff_vl_q     <= '0;
            idx_q        <= '0;
            vm_q         <= 1'b0;
            masks_q      <= '0;
            vd_q         <= '0;
            error_q      <= 1'b0;
            err_vstart_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vd_q         <= vd_d;
            error_q      <= error_d;
            err_vstart_q <= err_vstart_d;
            if (latch_en) begin
                store_q  <= is_store;
                eew_q    <= eew;
                base_q   <= base_addr;
                stride_q <= stride;
                eff_vl_q <= eff_vl;
                vm_q     <= vm;
                masks_q  <= masks;
            end
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy       = (state_q == StAccess);
        done       = (state_q == StFinish);
        error      = done & error_q;
        err_vstart = err_vstart_q;
        vd_result  = vd_q;
    end

endmodule

// File: tb/tb_vector_lsu_sequencer.sv
// Self-checking bench for vector_lsu_sequencer: directed cases plus randomized
// operations compared against an element-walk reference model.
module tb_vector_lsu_sequencer;

    localparam int unsigned VLEN   = 128;
    localparam int unsigned ADDR_W = 32;

    logic              SYS_clk = 1'b0;
    logic              SYS_reset;
    logic              start, is_store, vm, busy, done, error;
    logic [1:0]        eew;
    logic [ADDR_W-1:0] base_addr, mem_addr;
    logic [31:0]       stride, vl, vstart, err_vstart, mem_wdata, mem_rdata;
    logic [VLEN-1:0]   masks, vs_data, vd_result;
    logic              mem_req, mem_we, mem_ready;
    logic [3:0]        mem_wstrb;

    logic [31:0] mem [1024];
    assign mem_rdata = mem[mem_addr[11:2]];

    always #5 SYS_clk = ~SYS_clk;

    vector_lsu_sequencer #(.VLEN(VLEN), .ADDR_W(ADDR_W)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .start(start), .is_store(is_store),
        .eew(eew), .base_addr(base_addr), .stride(stride), .vl(vl), .vstart(vstart),
        .vm(vm), .masks(masks), .vs_data(vs_data), .busy(busy), .done(done),
        .error(error), .err_vstart(err_vstart), .vd_result(vd_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    acc_t            exp_q[$];
    logic [VLEN-1:0] exp_vd;
    logic            exp_err;
    logic [31:0]     exp_ev;
    int              exp_steps;

    logic [VLEN-1:0] obs_vd;
    logic            obs_err;
    logic [31:0]     obs_ev;
    int              obs_lat;

    // Reference: walk elements vstart..eff_vl-1 and list the accesses the engine must make
    task automatic model(input logic st, input logic [1:0] e, input logic [31:0] base,
                         input logic [31:0] strd, input logic [31:0] vl_v,
                         input logic [31:0] vs_v, input logic vm_v,
                         input logic [VLEN-1:0] mk, input logic [VLEN-1:0] vsd);
        int          w, max_el, eff;
        logic [31:0] a, rd, el;
        logic [63:0] emask;
        exp_q.delete();
        exp_vd    = vsd;
        exp_err   = 1'b0;
        exp_ev    = 0;
        exp_steps = 0;
        if (e == 2'd3) begin
            exp_err = 1'b1;
            exp_ev  = vs_v;
            return;
        end
        w      = 8 << e;
        max_el = VLEN / w;
        eff    = (vl_v < 32'(max_el)) ? int'(vl_v) : max_el;
        emask  = (64'd1 << w) - 64'd1;
        for (int i = int'(vs_v); i < eff; i++) begin
            exp_steps++;
            if (!vm_v && !mk[i]) continue;
            a = base + 32'(i) * strd;
            if ((a % (32'd1 << e)) != 0) begin
                exp_err = 1'b1;
                exp_ev  = 32'(i);
                break;
            end
            if (st) begin
                el = 32'((vsd >> (i * w)) & VLEN'(emask));
                exp_q.push_back('{addr: a & ~32'd3, we: 1'b1,
                                  wdata: 32'(el << (8 * (a % 4))),
                                  wstrb: 4'(((1 << (1 << e)) - 1) << (a % 4))});
            end else begin
                rd = mem[a[11:2]];
                el = 32'((64'(rd) >> (8 * (a % 4))) & emask);
                for (int j = 0; j < w; j++) exp_vd[i * w + j] = el[j];
                exp_q.push_back('{addr: a & ~32'd3, we: 1'b0, wdata: 32'd0, wstrb: 4'd0});
            end
        end
    endtask

    task automatic scramble_inputs();
        start     = 1'($urandom % 2);
        is_store  = 1'($urandom % 2);
        eew       = 2'($urandom % 4);
        base_addr = $urandom;
        stride    = $urandom;
        vl        = $urandom;
        vstart    = $urandom;
        vm        = 1'($urandom % 2);
        masks     = {$urandom, $urandom, $urandom, $urandom};
        vs_data   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Issue one operation and follow it cycle by cycle until done (bounded)
    task automatic run_op(input string nm, input logic st, input logic [1:0] e,
                          input logic [31:0] base, input logic [31:0] strd,
                          input logic [31:0] vl_v, input logic [31:0] vs_v, input logic vm_v,
                          input logic [VLEN-1:0] mk, input logic [VLEN-1:0] vsd,
                          input bit rand_ready, input bit noise);
        int   cyc, waits;
        bit   seen_done;
        acc_t h;
        model(st, e, base, strd, vl_v, vs_v, vm_v, mk, vsd);
        start = 1'b1; is_store = st; eew = e; base_addr = base; stride = strd;
        vl = vl_v; vstart = vs_v; vm = vm_v; masks = mk; vs_data = vsd;
        cyc = 0; waits = 0; seen_done = 0;
        while (!seen_done && cyc < 300) begin
            @(negedge SYS_clk);
            cyc++;
            if (noise) scramble_inputs();
            else start = 1'b0;
            mem_ready = rand_ready ? 1'($urandom % 3 != 0) : 1'b1;
            if (done) begin
                seen_done = 1;
                obs_lat = cyc; obs_vd = vd_result; obs_err = error; obs_ev = err_vstart;
                check({nm, "_latency"}, 128'(cyc), 128'(1 + exp_steps + waits));
                check({nm, "_busy_at_done"}, busy, 1'b0);
                check({nm, "_error"}, error, exp_err);
                if (exp_err) check({nm, "_err_vstart"}, err_vstart, exp_ev);
                check({nm, "_vd"}, vd_result, exp_vd);
                check({nm, "_missing_accesses"}, 128'(exp_q.size()), 128'(0));
                if (noise) start = 1'b1;
            end else begin
                check({nm, "_busy"}, busy, 1'b1);
                if (mem_req) begin
                    check({nm, "_req_expected"}, exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        h = exp_q[0];
                        check({nm, "_addr"}, mem_addr, h.addr);
                        check({nm, "_we"}, mem_we, h.we);
                        if (h.we) begin
                            check({nm, "_wdata"}, mem_wdata, h.wdata);
                            check({nm, "_wstrb"}, mem_wstrb, h.wstrb);
                        end
                        if (mem_ready) begin
                            for (int b = 0; b < 4; b++)
                                if (h.we && h.wstrb[b]) mem[h.addr[11:2]][8*b +: 8] = h.wdata[8*b +: 8];
                            void'(exp_q.pop_front());
                        end else begin
                            waits++;
                        end
                    end
                end
            end
        end
        if (!seen_done) check({nm, "_timeout"}, seen_done, 1'b1);
        start = 1'b0;
        mem_ready = 1'b1;
        @(negedge SYS_clk);
        check({nm, "_idle_busy"}, busy, 1'b0);
        check({nm, "_idle_done"}, done, 1'b0);
    endtask

    initial begin
        logic [1:0]  e;
        logic [31:0] strd, base, bytes;
        SYS_reset = 1'b1; start = 1'b0; is_store = 1'b0; eew = '0; base_addr = '0;
        stride = '0; vl = '0; vstart = '0; vm = 1'b1; masks = '0; vs_data = '0;
        mem_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (2) @(negedge SYS_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_wstrb", mem_wstrb, 4'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_err_vstart", err_vstart, 32'd0);
        check("rst_vd", vd_result, 128'd0);
        SYS_reset = 1'b0;
        @(negedge SYS_clk);

        // Unit-stride word load
        mem[32'h40] = 32'h11111111; mem[32'h41] = 32'h22222222;
        mem[32'h42] = 32'h33333333; mem[32'h43] = 32'h44444444;
        run_op("ld32", 1'b0, 2'd2, 32'h100, 32'd4, 32'd4, 32'd0, 1'b1, '0, '0, 1'b0, 1'b0);
        check("ld32_vd_const", obs_vd, 128'h44444444_33333333_22222222_11111111);
        check("ld32_lat_const", 128'(obs_lat), 128'd5);

        // Byte stores into one word, lanes 1..3
        run_op("st8", 1'b1, 2'd0, 32'h201, 32'd1, 32'd3, 32'd0, 1'b1, '0,
               128'hCCBBAA, 1'b0, 1'b0);
        check("st8_mem_word", mem[32'h80][31:8], 24'hCCBBAA);
        check("st8_lat_const", 128'(obs_lat), 128'd4);

        // Masked load keeps inactive slices
        run_op("mld", 1'b0, 2'd2, 32'h100, 32'd4, 32'd4, 32'd0, 1'b0, 128'b0101,
               {4{32'hDEADBEEF}}, 1'b0, 1'b0);
        check("mld_slice1", obs_vd[63:32], 32'hDEADBEEF);
        check("mld_slice3", obs_vd[127:96], 32'hDEADBEEF);
        check("mld_slice2", obs_vd[95:64], 32'h33333333);

        // Misaligned second element
        run_op("mis", 1'b0, 2'd2, 32'h100, 32'd6, 32'd4, 32'd0, 1'b1, '0, '0, 1'b0, 1'b0);
        check("mis_err", obs_err, 1'b1);
        check("mis_ev", obs_ev, 32'd1);

        // vl clamps to VLEN/32 elements
        run_op("clamp", 1'b0, 2'd2, 32'h100, 32'd4, 32'd10, 32'd0, 1'b1, '0, '0, 1'b0, 1'b0);
        check("clamp_lat", 128'(obs_lat), 128'd5);

        // vstart at eff_vl: no access
        run_op("vst4", 1'b0, 2'd2, 32'h100, 32'd4, 32'd4, 32'd4, 1'b1, '0,
               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 1'b0);
        check("vst4_lat", 128'(obs_lat), 128'd1);
        check("vst4_vd", obs_vd, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        // Illegal eew
        run_op("eew3", 1'b1, 2'd3, 32'h100, 32'd8, 32'd2, 32'd3, 1'b1, '0, '0, 1'b0, 1'b0);
        check("eew3_ev", obs_ev, 32'd3);

        // Wait states then reset mid-operation
        start = 1'b1; is_store = 1'b0; eew = 2'd2; base_addr = 32'h300; stride = 32'd4;
        vl = 32'd4; vstart = 32'd0; vm = 1'b1; mem_ready = 1'b0;
        @(negedge SYS_clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wait_req", mem_req, 1'b1);
            check("wait_addr", mem_addr, 32'h300);
            if (k == 3) SYS_reset = 1'b1;
            else @(negedge SYS_clk);
        end
        @(negedge SYS_clk);
        check("abort_busy", busy, 1'b0);
        check("abort_req", mem_req, 1'b0);
        check("abort_done", done, 1'b0);
        SYS_reset = 1'b0; mem_ready = 1'b1;
        @(negedge SYS_clk);
        check("abort_no_done", done, 1'b0);

        // Randomized operations with wait states and input noise while busy
        for (int n = 0; n < 40; n++) begin
            e     = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            bytes = 32'd1 << e;
            case ($urandom % 4)
                0:       strd = bytes;
                1:       strd = bytes * ($urandom % 4);
                2:       strd = -(bytes * (1 + $urandom % 3));
                default: strd = ($urandom % 9) - 4;
            endcase
            base = $urandom % 4096;
            if ($urandom % 4 != 0) base = base & ~(bytes - 1);
            run_op("rnd", 1'($urandom % 2), e, base, strd, $urandom % 20, $urandom % 6,
                   1'($urandom % 2), {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
